clic_irq_gate: RTL

Interrupt-take stage between the CLIC arbiter and `clic_csr_regfile`. It latches the arbiter's winning pending interrupt and checks it every cycle against the hart's live interrupt-control state (`irq_ctrl_t`, current privilege). When a retiring instruction is available, it fires a one-cycle `irq_t` to the CSR regfile and claims the interrupt back to the CLIC. It then holds off for a fixed number of cycles, so that the regfile's updated `mil`/`sil`/`mie`/`sie` take effect before the next candidate is evaluated.

---
 rtl/clic_tb_pkg.sv | 60 ++++++
 rtl/clic_irq_eligible.sv | 41 ++++
 rtl/clic_irq_gate.sv | 133 +++++++++++++
 3 files changed

// File: rtl/clic_tb_pkg.sv
// rtl/clic_tb_pkg.sv - shared CLIC interrupt types and helpers
// Purpose: privilege modes, interrupt-control view, take request, gate FSM
//          states and the latched candidate used by clic_irq_gate.
// Ports:   none (package).
package clic_tb_pkg;

  // Width of the exception code carried in a take request; IDs wider than
  // this are truncated, narrower IDs are zero-extended.
  localparam int EXCODE_W  = 8;
  // Storage width for candidate IDs; gate instances use ID_W <= CAND_ID_W.
  localparam int CAND_ID_W = 16;

  typedef enum logic [1:0] {
    U_MODE = 2'b00,
    S_MODE = 2'b01,
    M_MODE = 2'b11
  } mode_t;

  typedef struct packed {
    logic [7:0] mil;
    logic [7:0] sil;
  } mintstatus_t;

  typedef struct packed {
    logic        mie;
    logic        sie;
    logic [7:0]  mintthresh;
    logic [7:0]  sintthresh;
    mintstatus_t mintstatus;
    logic        claim;
  } irq_ctrl_t;

  typedef struct packed {
    logic                valid;
    mode_t               irq_priv;
    logic [7:0]          irq_lvl;
    logic                shv;
    logic [EXCODE_W-1:0] excode;
    mode_t               hart_priv_lvl;
    logic                hart_ie;
  } irq_t;

  typedef enum logic [1:0] {
    GATE_IDLE     = 2'd0,
    GATE_ARMED    = 2'd1,
    GATE_COOLDOWN = 2'd2
  } gate_state_e;

  typedef struct packed {
    logic [CAND_ID_W-1:0] id;
    logic [7:0]           level;
    mode_t                priv;
    logic                 shv;
  } irq_cand_t;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clic_irq_eligible.sv
// rtl/clic_irq_eligible.sv - combinational M/S eligibility check for a candidate
// Purpose: decides whether the latched candidate may be taken given the
//          hart's live interrupt-control state and privilege.
// Ports:   cand_i      latched candidate {id, level, priv, shv}
//          irq_ctrl_i  mie/sie, thresholds, mintstatus (claim ignored)
//          priv_lvl_i  current hart privilege
//          elig_m_o    candidate is an M interrupt that may be taken now
//          elig_s_o    candidate is an S interrupt that may be taken now
module clic_irq_eligible
  import clic_tb_pkg::*;
(
  input  irq_cand_t cand_i,
  input  irq_ctrl_t irq_ctrl_i,
  input  mode_t     priv_lvl_i,
  output logic      elig_m_o,
  output logic      elig_s_o
);

  logic [7:0] m_floor;
  logic [7:0] s_floor;
  logic       unused_fields;

  // The effective level floor is whichever is higher: the level already
  // being serviced or the software threshold.
  assign m_floor = max8(irq_ctrl_i.mintstatus.mil, irq_ctrl_i.mintthresh);
  assign s_floor = max8(irq_ctrl_i.mintstatus.sil, irq_ctrl_i.sintthresh);

  assign elig_m_o = (cand_i.priv == M_MODE)
                  && ((priv_lvl_i != M_MODE) || irq_ctrl_i.mie)
                  && (cand_i.level > m_floor);

  // S interrupts are never taken while the hart runs in M; from U they are
  // globally enabled regardless of sie.
  assign elig_s_o = (cand_i.priv == S_MODE)
                  && (priv_lvl_i != M_MODE)
                  && ((priv_lvl_i == U_MODE) || irq_ctrl_i.sie)
                  && (cand_i.level > s_floor);

  assign unused_fields = ^{cand_i.id, cand_i.shv, irq_ctrl_i.claim};

endmodule

// File: rtl/clic_irq_gate.sv
// rtl/clic_irq_gate.sv - interrupt-take gate between CLIC arbiter and CSR regfile
// Purpose: latches the arbiter winner, checks it each cycle against live
//          interrupt control, fires a one-cycle take plus claim when an
//          instruction retires, then holds off COOLDOWN_CYCLES cycles.
// Config:  CLIC_IRQ_GATE_PREEMPT_EN - when defined, a higher-level winner with
//          a different ID replaces the armed candidate.
// Ports:   clk_i, rst_i (sync, active-high)
//          clic_valid_i/id_i/level_i/priv_i/shv_i  arbiter winner
//          clic_claim_o, clic_claim_id_o           take acknowledge to CLIC
//          priv_lvl_i, irq_ctrl_i                  live hart state
//          inst_valid_i                            instruction retiring
//          irq_o                                   take request to regfile
module clic_irq_gate
  import clic_tb_pkg::*;
#(
  parameter int ID_W            = 10,
  parameter int COOLDOWN_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clic_valid_i,
  input  logic [ID_W-1:0] clic_id_i,
  input  logic [7:0]      clic_level_i,
  input  mode_t           clic_priv_i,
  input  logic            clic_shv_i,
  output logic            clic_claim_o,
  output logic [ID_W-1:0] clic_claim_id_o,
  input  mode_t           priv_lvl_i,
  input  irq_ctrl_t       irq_ctrl_i,
  input  logic            inst_valid_i,
  output irq_t            irq_o
);

  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_CYCLES);

  gate_state_e state_q, state_d;
  irq_cand_t   cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;

  irq_cand_t   new_cand;
  logic        elig_m;
  logic        elig_s;
  logic        fire;

  clic_irq_eligible u_eligible (
    .cand_i     (cand_q),
    .irq_ctrl_i (irq_ctrl_i),
    .priv_lvl_i (priv_lvl_i),
    .elig_m_o   (elig_m),
    .elig_s_o   (elig_s)
  );

  always_comb begin
    new_cand       = '0;
    new_cand.id    = CAND_ID_W'(clic_id_i);
    new_cand.level = clic_level_i;
    new_cand.priv  = clic_priv_i;
    new_cand.shv   = clic_shv_i;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;

    unique case (state_q)
      GATE_IDLE: begin
        if (clic_valid_i) begin
          cand_d  = new_cand;
          state_d = GATE_ARMED;
        end
      end

      GATE_ARMED: begin
        // Retraction has priority over an otherwise eligible take.
        if (!clic_valid_i) begin
          state_d = GATE_IDLE;
        end else if (inst_valid_i && (elig_m || elig_s) && !rst_i) begin
          fire    = 1'b1;
          cnt_d   = COOL_LOAD;
          state_d = GATE_COOLDOWN;
        end
`ifdef CLIC_IRQ_GATE_PREEMPT_EN
        // The take decision this cycle used the old candidate; the new one
        // becomes eligible from the next cycle.
        else if ((new_cand.id != cand_q.id) && (clic_level_i > cand_q.level)) begin
          cand_d = new_cand;
        end
`endif
      end

      GATE_COOLDOWN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = GATE_IDLE;
        end
      end

      default: state_d = GATE_IDLE;
    endcase
  end

  always_comb begin
    irq_o           = '0;
    clic_claim_o    = 1'b0;
    clic_claim_id_o = '0;
    if (fire) begin
      irq_o.valid         = 1'b1;
      irq_o.irq_priv      = cand_q.priv;
      irq_o.irq_lvl       = cand_q.level;
      irq_o.shv           = cand_q.shv;
      irq_o.excode        = EXCODE_W'(cand_q.id);
      irq_o.hart_priv_lvl = priv_lvl_i;
      irq_o.hart_ie       = (cand_q.priv == M_MODE) ? irq_ctrl_i.mie : irq_ctrl_i.sie;
      clic_claim_o        = 1'b1;
      clic_claim_id_o     = ID_W'(cand_q.id);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GATE_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
